// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the reg_file_sb register file slice.
package reg_file_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Widest packed bus / field the unpack helper accepts.
    localparam int BUS_MAX   = 2048;
    localparam int FIELD_MAX = 64;

    // Returns field p of width w from a packed bus of equal-width fields.
    function automatic logic [FIELD_MAX-1:0] unpack_port(
        input logic [BUS_MAX-1:0] bus,
        input int                 p,
        input int                 w
    );
        logic [BUS_MAX-1:0]   sh;
        logic [FIELD_MAX-1:0] f;
        sh = bus >> (p * w);
        f  = '0;
        for (int i = 0; i < FIELD_MAX; i++) begin
            if (i < w) f[i] = sh[i];
        end
        return f;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue sets, write clears, set wins on a same-cycle clash.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [NRD-1:0]           rd_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
        busy_nxt = busy;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) busy_nxt[wr_addr[w]] = 1'b0;
        end
        if (iss_en) busy_nxt[iss_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)      busy <= '0;
        else if (run) busy <= busy_nxt;
    end

    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            logic hit;
            hit = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (BYPASS != 0 && wr_en[w] && wr_addr[w] == rd_addr[p]) hit = 1'b1;
            end
            rd_busy[p] = run && (rd_addr[p] != '0) && !hit && busy[rd_addr[p]];
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with write bypass, busy scoreboard and a
// sequential clear sweep that runs after every reset.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr
);

    logic [NRD-1:0][AW-1:0]   rd_addr_a;
    logic [NWR-1:0][AW-1:0]   wr_addr_a;
    logic [NWR-1:0][XLEN-1:0] wr_data_a;

    for (genvar p = 0; p < NRD; p++) begin : g_rd_unpack
        assign rd_addr_a[p] = AW'(unpack_port(BUS_MAX'(rd_addr), p, AW));
    end
    for (genvar w = 0; w < NWR; w++) begin : g_wr_unpack
        assign wr_addr_a[w] = AW'(unpack_port(BUS_MAX'(wr_addr), w, AW));
        assign wr_data_a[w] = XLEN'(unpack_port(BUS_MAX'(wr_data), w, XLEN));
    end

    rf_state_e        state;
    logic [AW-1:0]    clr_idx;
    logic [XLEN-1:0]  regs [NREGS];
    logic             run;

    assign run = (state == RF_RUN);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
        if (rst) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else if (state == RF_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == AW'(NREGS - 1)) begin
                state <= RF_RUN;
                ready <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset branch; the clear sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_CLEAR) begin
                regs[clr_idx] <= '0;
            end else begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && wr_addr_a[w] != '0) regs[wr_addr_a[w]] <= wr_data_a[w];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [XLEN-1:0] rd_val;
        always_comb begin
            rd_val = regs[rd_addr_a[p]];
            // Later ports overwrite earlier ones, so the highest writer wins.
            for (int w = 0; w < NWR; w++) begin
                if (BYPASS != 0 && wr_en[w] && wr_addr_a[w] == rd_addr_a[p]) rd_val = wr_data_a[w];
            end
            if (!run || rd_addr_a[p] == '0) rd_val = '0;
        end
        assign rd_data[p*XLEN +: XLEN] = rd_val;
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .rd_addr  (rd_addr_a),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr_a),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_busy  (rd_busy)
    );

endmodule
